// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, lookahead group width and the flag bundle.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  localparam int unsigned GROUP_W = 4;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/cla_group4.sv
// One 4-bit carry-lookahead group: sum, carry-out and group propagate/generate.
module cla_group4
  import alu_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] sum,
  output logic               cout,
  output logic               p,
  output logic               g
);

  logic [3:0] pi;
  logic [3:0] gi;
  logic [3:0] c;

  assign pi = a ^ b;
  assign gi = a & b;

  // Every internal carry is a flat sum of products on cin; no ripple inside the group.
  assign c[0] = cin;
  assign c[1] = gi[0] | (pi[0] & cin);
  assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
  assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
              | (pi[2] & pi[1] & pi[0] & cin);

  assign p    = &pi;
  assign g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
              | (pi[3] & pi[2] & pi[1] & gi[0]);
  assign cout = g | (p & cin);
  assign sum  = pi ^ c;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready backpressure and ALU flags.
// Each stage resolves GROUPS_PER_STAGE 4-bit groups; the stage carry is registered between stages.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned NGROUPS = WIDTH / GROUP_W;
  localparam int unsigned LAT     = NGROUPS / GROUPS_PER_STAGE;
  localparam int unsigned STAGE_W = GROUP_W * GROUPS_PER_STAGE;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] b_prep;
  logic             c0;
  logic             stall;

  // Stage inputs (from ports or previous register) and next-register values
  logic [WIDTH-1:0] a_in [LAT];
  logic [WIDTH-1:0] b_in [LAT];
  logic [WIDTH-1:0] s_in [LAT];
  logic             c_in [LAT];
  logic             v_in [LAT];
  logic             am_in[LAT];
  logic             bm_in[LAT];
  logic [WIDTH-1:0] a_nxt[LAT];
  logic [WIDTH-1:0] b_nxt[LAT];
  logic [WIDTH-1:0] s_nxt[LAT];
  logic             c_nxt[LAT];

  // Stage registers
  logic             v_q [LAT];
  logic [WIDTH-1:0] a_q [LAT];
  logic [WIDTH-1:0] b_q [LAT];
  logic [WIDTH-1:0] s_q [LAT];
  logic             c_q [LAT];
  logic             am_q[LAT];
  logic             bm_q[LAT];

  logic [WIDTH-1:0]   gsum;
  logic [NGROUPS-1:0] gcin;
  logic [NGROUPS-1:0] gcout;
  logic [NGROUPS-1:0] gp;
  logic [NGROUPS-1:0] gg;

  flags_t flags;

  // Operand preparation: subtraction is A + ~B + c0
  always_comb begin
    b_prep = in_b;
    c0     = 1'b0;
    case (in_op)
      OP_ADD: begin
        b_prep = in_b;
        c0     = 1'b0;
      end
      OP_ADC: begin
        b_prep = in_b;
        c0     = in_cin;
      end
      OP_SUB: begin
        b_prep = ~in_b;
        c0     = 1'b1;
      end
      default: begin
        b_prep = ~in_b;
        c0     = in_cin;
      end
    endcase
  end

  assign stall    = v_q[LAT-1] && !out_ready;
  assign in_ready = !stall;

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam logic [WIDTH-1:0] SMASK = (ONES >> (WIDTH - STAGE_W)) << (s * STAGE_W);
    localparam logic [WIDTH-1:0] REM   = ONES << ((s + 1) * STAGE_W);

    if (s == 0) begin : g_first
      assign v_in[s]  = in_valid && in_ready;
      assign a_in[s]  = in_a;
      assign b_in[s]  = b_prep;
      assign s_in[s]  = '0;
      assign c_in[s]  = c0;
      assign am_in[s] = in_a[WIDTH-1];
      assign bm_in[s] = b_prep[WIDTH-1];
    end else begin : g_next
      assign v_in[s]  = v_q[s-1];
      assign a_in[s]  = a_q[s-1];
      assign b_in[s]  = b_q[s-1];
      assign s_in[s]  = s_q[s-1];
      assign c_in[s]  = c_q[s-1];
      assign am_in[s] = am_q[s-1];
      assign bm_in[s] = bm_q[s-1];
    end

    // Only the not-yet-added operand slices travel forward; finished slices drop to zero.
    assign a_nxt[s] = a_in[s] & REM;
    assign b_nxt[s] = b_in[s] & REM;
    assign s_nxt[s] = (s_in[s] & ~SMASK) | (gsum & SMASK);
    assign c_nxt[s] = gcout[(s + 1) * GROUPS_PER_STAGE - 1];
  end

  for (genvar g = 0; g < NGROUPS; g++) begin : g_grp
    localparam int unsigned ST = g / GROUPS_PER_STAGE;

    if (g % GROUPS_PER_STAGE == 0) begin : g_cin_stage
      assign gcin[g] = c_in[ST];
    end else begin : g_cin_chain
      assign gcin[g] = gcout[g-1];
    end

    cla_group4 u_grp (
      .a   (a_in[ST][g*GROUP_W +: GROUP_W]),
      .b   (b_in[ST][g*GROUP_W +: GROUP_W]),
      .cin (gcin[g]),
      .sum (gsum[g*GROUP_W +: GROUP_W]),
      .cout(gcout[g]),
      .p   (gp[g]),
      .g   (gg[g])
    );
  end

  // Group P/G are kept for a wider lookahead tree; here group carries ripple within a stage.
  logic unused_pg;
  assign unused_pg = ^{gp, gg};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        v_q[s]  <= 1'b0;
        a_q[s]  <= '0;
        b_q[s]  <= '0;
        s_q[s]  <= '0;
        c_q[s]  <= 1'b0;
        am_q[s] <= 1'b0;
        bm_q[s] <= 1'b0;
      end
    end else if (!stall) begin
      for (int unsigned s = 0; s < LAT; s++) begin
        v_q[s]  <= v_in[s];
        a_q[s]  <= a_nxt[s];
        b_q[s]  <= b_nxt[s];
        s_q[s]  <= s_nxt[s];
        c_q[s]  <= c_nxt[s];
        am_q[s] <= am_in[s];
        bm_q[s] <= bm_in[s];
      end
    end
  end

  // Flags derive from the final register, so they add no cycle of latency.
  assign flags.cout = c_q[LAT-1];
  assign flags.ovf  = (am_q[LAT-1] == bm_q[LAT-1]) && (s_q[LAT-1][WIDTH-1] != am_q[LAT-1]);
  assign flags.zero = (s_q[LAT-1] == '0);
  assign flags.neg  = s_q[LAT-1][WIDTH-1];

  assign out_valid = v_q[LAT-1];
  assign out_sum   = s_q[LAT-1];
  assign out_cout  = flags.cout;
  assign out_ovf   = flags.ovf;
  assign out_zero  = flags.zero;
  assign out_neg   = flags.neg;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: arithmetic reference model with a cycle-accurate handshake view.
module tb_pipelined_cla_addsub;
  import alu_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned GPS = 1;
  localparam int unsigned LAT = W / (4 * GPS);

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;
  logic         out_neg;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(W), .GROUPS_PER_STAGE(GPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_zero(out_zero), .out_neg(out_neg)
  );

  typedef struct {
    bit           v;
    logic [W-1:0] sum;
    bit           cout;
    bit           ovf;
  } res_t;

  res_t mp[LAT];
  int   total = 0;
  int   bad = 0;
  int   out_xfers = 0;
  bit   chk_en = 0;
  bit   last_rst = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer sums, signed range test for overflow
  function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    res_t   r;
    longint m, ua, ub, c, full, sa, sb, s;
    m    = longint'(1) << W;
    ua   = longint'(a);
    c    = (op == OP_ADD) ? 0 : (op == OP_SUB) ? 1 : longint'(cin);
    ub   = (op == OP_SUB || op == OP_SBB) ? (m - 1 - longint'(b)) : longint'(b);
    full = ua + ub + c;
    r.v    = 1'b1;
    r.sum  = full[W-1:0];
    r.cout = full[W];
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    s  = sa + sb + c;
    r.ovf = (s >= m / 2) || (s < -(m / 2));
    return r;
  endfunction

  function automatic bit model_busy();
    bit busy = 1'b0;
    for (int i = 0; i < LAT; i++) busy |= mp[i].v;
    return busy;
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {(W-1){1'b1}}};
      3:       v = {1'b1, {(W-1){1'b0}}};
      4:       v = W'(1);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Handshake view: LAT slots that advance together unless the last holds an unaccepted result
  always @(posedge clk) begin
    bit st;
    st = mp[LAT-1].v && !out_ready;
    last_rst = rst;
    if (rst) begin
      for (int i = 0; i < LAT; i++) mp[i].v = 1'b0;
    end else if (!st) begin
      for (int i = LAT - 1; i > 0; i--) mp[i] = mp[i-1];
      mp[0]   = model(in_op, in_a, in_b, in_cin);
      mp[0].v = in_valid;
    end
  end

  // Per-cycle comparison of DUT against the model, plus output hold during stalls
  bit           prev_stall = 0;
  logic [W-1:0] prev_sum;
  logic [3:0]   prev_flags;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, mp[LAT-1].v);
      chk("in_ready", in_ready, !(mp[LAT-1].v && !out_ready));
      if (mp[LAT-1].v) begin
        chk("sum", out_sum, mp[LAT-1].sum);
        chk("cout", out_cout, mp[LAT-1].cout);
        chk("ovf", out_ovf, mp[LAT-1].ovf);
        chk("zero", out_zero, mp[LAT-1].sum == '0);
        chk("neg", out_neg, mp[LAT-1].sum[W-1]);
      end
      if (prev_stall && !last_rst) begin
        chk("hold sum", out_sum, prev_sum);
        chk("hold flags", {out_cout, out_ovf, out_zero, out_neg}, prev_flags);
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_flags = {out_cout, out_ovf, out_zero, out_neg};
      if (out_valid && out_ready) out_xfers++;
    end
  end

  task automatic chk_reset_state(input string nm);
    chk({nm, " out_valid"}, out_valid, 1'b0);
    chk({nm, " in_ready"}, in_ready, 1'b1);
    chk({nm, " sum"}, out_sum, '0);
    chk({nm, " cout"}, out_cout, 1'b0);
    chk({nm, " ovf"}, out_ovf, 1'b0);
    chk({nm, " zero"}, out_zero, 1'b1);
    chk({nm, " neg"}, out_neg, 1'b0);
  endtask

  // Single op on an idle pipe; pins both DUT and model to hand-computed values
  task automatic dir_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [W-1:0] es,
                        input bit ec, input bit eo, input bit ez, input bit en);
    int   n;
    res_t r;
    r = model(op, a, b, cin);
    chk({nm, " model sum"}, r.sum, es);
    chk({nm, " model cout"}, r.cout, ec);
    chk({nm, " model ovf"}, r.ovf, eo);
    in_op = op; in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({nm, " latency"}, n, LAT);
    chk({nm, " sum"}, out_sum, es);
    chk({nm, " cout"}, out_cout, ec);
    chk({nm, " ovf"}, out_ovf, eo);
    chk({nm, " zero"}, out_zero, ez);
    chk({nm, " neg"}, out_neg, en);
    @(posedge clk); #1;
  endtask

  // Random op source honouring the handshake; called and returns at posedge+1
  task automatic run(input int nops, input int rdy_pct, input int vld_pct, input int max_cyc);
    int sent = 0;
    int cyc = 0;
    bit acc;
    while (sent < nops && cyc < max_cyc) begin
      if (!in_valid && $urandom_range(99) < vld_pct) begin
        in_op    = 2'($urandom_range(3));
        in_a     = rnd_val();
        in_b     = rnd_val();
        in_cin   = 1'($urandom_range(1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk("ops sent", sent, nops);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (model_busy() && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", model_busy(), 1'b0);
  endtask

  initial begin
    int x0;
    int sent;
    int stalls;
    int cyc;
    bit acc;
    logic [W-1:0] snap_sum;
    logic [3:0]   snap_flags;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_ADD; in_cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;

    dir_op("add",      OP_ADD, 16'h1234, 16'h4321, 1'b0, 16'h5555, 0, 0, 0, 0);
    dir_op("sub_brw",  OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 0, 1);
    dir_op("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
    dir_op("adc_wrap", OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1, 0, 1, 0);
    dir_op("sbb_brw",  OP_SBB, 16'h0005, 16'h0003, 1'b0, 16'h0001, 1, 0, 0, 0);
    dir_op("sbb_nb",   OP_SBB, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1, 0, 0, 0);
    dir_op("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
    dir_op("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1, 1, 0, 0);
    dir_op("add_cin",  OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 0, 0, 0, 0);

    // Back-to-back stream with no backpressure
    x0 = out_xfers;
    run(8, 100, 100, 50);
    drain();
    chk("stream results", out_xfers - x0, 8);

    // Consumer stalls for 3 cycles at the first result
    x0 = out_xfers; sent = 0; stalls = 0; cyc = 0;
    out_ready = 1'b0;
    while ((sent < 6 || stalls < 3) && cyc < 100) begin
      if (!in_valid && sent < 6) begin
        in_op = 2'($urandom_range(3)); in_a = rnd_val(); in_b = rnd_val();
        in_cin = 1'($urandom_range(1)); in_valid = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) begin
        stalls++;
        chk("stall in_ready", in_ready, 1'b0);
        if (stalls == 1) begin
          snap_sum = out_sum;
          snap_flags = {out_cout, out_ovf, out_zero, out_neg};
        end else begin
          chk("stall frozen sum", out_sum, snap_sum);
          chk("stall frozen flags", {out_cout, out_ovf, out_zero, out_neg}, snap_flags);
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (stalls == 3) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("stall cycles", stalls, 3);
    drain();
    chk("stall results", out_xfers - x0, 6);

    // Reset with three operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = OP_ADD; in_a = rnd_val(); in_b = rnd_val(); in_cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      chk("midrst no stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // Random traffic with random backpressure
    run(3000, 70, 80, 20000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath.
- Operands are split into 4-bit lookahead groups. Carry ripples group-to-group, with a register stage after every GROUPS_PER_STAGE groups.
- Valid/ready handshake with full backpressure. Throughput is one operation per cycle.
- Produces sum, carry-out, signed overflow, zero and negative flags for the ALU flag register.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- GROUPS_PER_STAGE, 1, number of 4-bit groups evaluated per pipeline stage; must divide WIDTH/4.
- Derived constant (not overridable): LAT = WIDTH/(4*GROUPS_PER_STAGE), the pipeline latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation present on in_*
- in_ready  output  1  block accepts operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB
- in_cin  input  1  carry-in for ADC; not-borrow for SBB (1 = no borrow); ignored for ADD/SUB
- out_valid  output  1  result present on out_*
- out_ready  input  1  consumer accepts result this cycle
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of the MSB (for SUB/SBB: 1 = no borrow)
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_sum == 0
- out_neg  output  1  out_sum[WIDTH-1]

Behaviour:
- Operand preparation:
  - B' = ~in_b for SUB/SBB, in_b otherwise.
  - c0 = 0 for ADD, 1 for SUB, in_cin for ADC/SBB.
  - Result = in_a + B' + c0, mod 2^WIDTH; out_cout is bit WIDTH of the full sum.
- Carry logic: each group computes Pi = a^b and Gi = a&b, carries by lookahead within the group, and group P/G.
  - Group carry-in is the previous group's carry-out, taken from the same stage or from the pipeline register.
- Pipeline registers per stage carry: valid bit, remaining unprocessed A/B' slices, completed sum slices, stage carry, and the MSB operand bits needed for overflow.
- Overflow: out_ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Flags are computed in the final stage, combinationally from the registered sum; no extra latency.
- Latency: an input accepted at cycle t presents out_valid at t+LAT if unstalled. Back-to-back accepts give back-to-back results.
- Handshake:
  - Stall condition: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - When stalled, every stage register holds, including bubbles; there is no bubble compression.
  - Transfer on the input side happens when in_valid && in_ready. Transfer on the output side happens when out_valid && out_ready.
  - When not stalled, a stage with no incoming operation loads valid=0.
- Outputs are stable while out_valid && !out_ready; out_* never change until the result transfers.
- in_valid without in_ready: operation is not captured; the source must hold it.
- Simultaneous output transfer and input accept in the same cycle is allowed and loses no data.
- Reset:
  - rst=1 clears every stage valid bit and every data/flag register to 0 on the next edge, including mid-operation.
  - In-flight operations are discarded.
  - After reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=1 (derived from sum=0, valid=0), out_neg=0, in_ready=1.
  - Takes priority over all handshakes.
- Wrap-around:
  - ADD of 0xFFFF+0x0001 (WIDTH=16) gives sum 0, cout 1, zero 1.
  - No saturation mode.
- Consumers must qualify out_zero with out_valid.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants OP_ADD=2'b00, OP_ADC=2'b01, OP_SUB=2'b10, OP_SBB=2'b11;
  - GROUP_W=4;
  - the flag-bundle typedef (cout, ovf, zero, neg) reused by the ALU flag register.
- One sub-module, cla_group4: 4-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, group P, group G.
  - Instantiated WIDTH/4 times via generate.

Test Plan:
- WIDTH=16, GPS=1 (LAT=4): ADD 0x1234+0x4321 accepted at cycle 0 -> out_valid at cycle 4, sum 0x5555, cout 0, ovf 0, zero 0, neg 0.
- SUB 0x0000-0x0001 -> sum 0xFFFF, cout 0 (borrow), ovf 0, neg 1. ADD 0x7FFF+0x0001 -> sum 0x8000, ovf 1, neg 1.
- ADC 0xFFFF+0x0000 with cin 1 -> sum 0x0000, cout 1, zero 1. SBB 0x0005-0x0003 with cin 0 -> sum 0x0001, cout 1.
- Stream 8 back-to-back ops, out_ready=1 -> 8 results on consecutive cycles, in order. Then hold out_ready=0 for 3 cycles at the first result -> in_ready=0, out_* frozen; release -> no loss or duplication.
- Assert rst for 1 cycle with 3 ops in flight -> next cycle out_valid=0, in_ready=1, all outputs at reset values; no stale result ever appears.
- Parameter sweep WIDTH=32 with GPS=1, 2, 8 (LAT 8, 4, 1): 10k random ops of all op codes vs. a behavioural model, with random out_ready backpressure -> all fields match, latency equals LAT when unstalled.
